// File: rtl/aca_csu_err_corr_if.sv
// Handshake/data bundle between the ACA-CSU error corrector and its producer/consumer.
// ACA_CONSIST_CHK_EN adds the sum_mismatch signal.
interface aca_csu_err_corr_if #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int CNTW  = 4
);
    localparam int NBLK = WIDTH / BLK;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   approx_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   corr_sum;
    logic [NBLK-1:0]  err_mask;
    logic             err_flag;
    logic [CNTW-1:0]  err_count;
`ifdef ACA_CONSIST_CHK_EN
    logic             sum_mismatch;
`endif

    modport master (
        output in_valid, a, b, approx_sum, out_ready,
        input  in_ready, out_valid, corr_sum, err_mask, err_flag, err_count
`ifdef ACA_CONSIST_CHK_EN
        , input sum_mismatch
`endif
    );

    modport slave (
        input  in_valid, a, b, approx_sum, out_ready,
        output in_ready, out_valid, corr_sum, err_mask, err_flag, err_count
`ifdef ACA_CONSIST_CHK_EN
        , output sum_mismatch
`endif
    );
endinterface

// File: rtl/aca_csu_err_corr.sv
// Block-serial error detector/corrector for the ACA-CSU approximate adder.
// Define ACA_CONSIST_CHK_EN to also cross-check approx_sum against the speculated carries.
module aca_csu_err_corr #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int CNTW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    aca_csu_err_corr_if.slave   bus
);
    localparam int NBLK = WIDTH / BLK;
    localparam int IDXW = $clog2(NBLK);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx_q;
    logic             c_exact_q;
    logic [WIDTH:0]   corr_sum_q;
    logic [NBLK-1:0]  err_mask_q;
    logic [CNTW-1:0]  err_count_q;

    // Per-block propagate/generate and the adder's speculated carry-in, from captured operands.
    logic [NBLK-1:0] blk_p;
    logic [NBLK-1:0] blk_g;
    logic [NBLK-1:0] spec_c;

    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
        logic [BLK:0] blk_sum0;
        assign blk_sum0  = {1'b0, a_q[gi*BLK +: BLK]} + {1'b0, b_q[gi*BLK +: BLK]};
        assign blk_g[gi] = blk_sum0[BLK];
        assign blk_p[gi] = &(a_q[gi*BLK +: BLK] ^ b_q[gi*BLK +: BLK]);
    end

    assign spec_c[0] = 1'b0;
    assign spec_c[1] = blk_g[0];
    for (genvar gi = 2; gi < NBLK; gi++) begin : g_spec
        assign spec_c[gi] = blk_p[gi-1] ? (a_q[BLK*(gi-1)-1] & b_q[BLK*(gi-1)-1])
                                        : blk_g[gi-1];
    end

    logic [BLK-1:0] a_blk;
    logic [BLK-1:0] b_blk;
    logic [BLK:0]   blk_sum;
    logic           cur_spec;
    logic           err_bit;
    logic           last_blk;

    assign a_blk    = a_q[idx_q*BLK +: BLK];
    assign b_blk    = b_q[idx_q*BLK +: BLK];
    assign blk_sum  = {1'b0, a_blk} + {1'b0, b_blk} + {{BLK{1'b0}}, c_exact_q};
    assign cur_spec = spec_c[idx_q];
    assign err_bit  = cur_spec ^ c_exact_q;
    assign last_blk = (idx_q == IDXW'(NBLK - 1));

`ifdef ACA_CONSIST_CHK_EN
    logic [WIDTH:0] approx_q;
    logic           sum_mismatch_q;
    logic [BLK:0]   spec_sum;
    logic           blk_mismatch;

    assign spec_sum     = {1'b0, a_blk} + {1'b0, b_blk} + {{BLK{1'b0}}, cur_spec};
    assign blk_mismatch = (spec_sum[BLK-1:0] != approx_q[idx_q*BLK +: BLK]) ||
                          (last_blk && (spec_sum[BLK] != approx_q[WIDTH]));
    assign bus.sum_mismatch = sum_mismatch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            approx_q       <= '0;
            sum_mismatch_q <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid) begin
            approx_q       <= bus.approx_sum;
            sum_mismatch_q <= 1'b0;
        end else if (state_q == SCAN && blk_mismatch) begin
            sum_mismatch_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            c_exact_q   <= 1'b0;
            corr_sum_q  <= '0;
            err_mask_q  <= '0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q         <= bus.a;
                        b_q         <= bus.b;
                        idx_q       <= '0;
                        c_exact_q   <= 1'b0;
                        err_mask_q  <= '0;
                        err_count_q <= '0;
                        in_ready_q  <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    corr_sum_q[idx_q*BLK +: BLK] <= blk_sum[BLK-1:0];
                    c_exact_q                    <= blk_sum[BLK];
                    err_mask_q[idx_q]            <= err_bit;
                    err_count_q                  <= err_count_q + CNTW'(err_bit);
                    if (last_blk) begin
                        corr_sum_q[WIDTH] <= blk_sum[BLK];
                        out_valid_q       <= 1'b1;
                        state_q           <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.corr_sum  = corr_sum_q;
    assign bus.err_mask  = err_mask_q;
    assign bus.err_flag  = |err_mask_q;
    assign bus.err_count = err_count_q;
endmodule
